// File: rtl/stream_demux_1to2_if.sv
// Valid/ready handshake bundle for the 1-to-2 packet demultiplexer.
// The slave view belongs to the demux and the master view to its environment.
interface stream_demux_1to2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_valid;
    logic             b_ready;

    modport slave (
        input  in_data, in_sel, in_last, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_last, a_valid, b_data, b_last, b_valid
    );

    modport master (
        output in_data, in_sel, in_last, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_last, a_valid, b_data, b_last, b_valid
    );
endinterface

// File: rtl/stream_demux_1to2.sv
// Packet-aware 1-to-2 stream demultiplexer: whole packets go to slot A or B,
// with the route taken from in_sel on the first beat and locked until the last beat.
module stream_demux_1to2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_demux_1to2_if.slave   bus,
    output logic [CNT_W-1:0]     a_pkt_cnt,
    output logic [CNT_W-1:0]     b_pkt_cnt
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_r;
    logic [WIDTH-1:0] a_data_r;
    logic [WIDTH-1:0] b_data_r;
    logic             a_last_r;
    logic             b_last_r;
    logic             a_valid_r;
    logic             b_valid_r;
    logic [CNT_W-1:0] a_cnt_r;
    logic [CNT_W-1:0] b_cnt_r;

    logic tgt_b_s;
    logic tgt_valid_s;
    logic tgt_ready_s;
    logic in_ready_s;
    logic accept_s;
    logic a_load_s;
    logic b_load_s;

    // Target selection and input acceptance; in_ready never looks at in_valid.
    always_comb begin
        tgt_b_s     = 1'b0;
        tgt_valid_s = 1'b0;
        tgt_ready_s = 1'b0;
        case (state_r)
            IDLE:    tgt_b_s = bus.in_sel;
            LOCK_A:  tgt_b_s = 1'b0;
            LOCK_B:  tgt_b_s = 1'b1;
            default: tgt_b_s = 1'b0;
        endcase
        if (tgt_b_s) begin
            tgt_valid_s = b_valid_r;
            tgt_ready_s = bus.b_ready;
        end else begin
            tgt_valid_s = a_valid_r;
            tgt_ready_s = bus.a_ready;
        end
        in_ready_s = ~tgt_valid_s | tgt_ready_s;
        accept_s   = bus.in_valid & in_ready_s;
        a_load_s   = accept_s & ~tgt_b_s;
        b_load_s   = accept_s & tgt_b_s;
    end

    // Route lock: held from the first accepted beat until the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else if (accept_s) begin
            if (bus.in_last) begin
                state_r <= IDLE;
            end else if (tgt_b_s) begin
                state_r <= LOCK_B;
            end else begin
                state_r <= LOCK_A;
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Slot A: load wins over drain so a simultaneous drain+load keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data_r  <= '0;
            a_last_r  <= 1'b0;
            a_valid_r <= 1'b0;
        end else if (a_load_s) begin
            a_data_r  <= bus.in_data;
            a_last_r  <= bus.in_last;
            a_valid_r <= 1'b1;
        end else if (a_valid_r && bus.a_ready) begin
            a_valid_r <= 1'b0;
        end else begin
            a_valid_r <= a_valid_r;
        end
    end

    // Slot B: same behaviour as slot A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_data_r  <= '0;
            b_last_r  <= 1'b0;
            b_valid_r <= 1'b0;
        end else if (b_load_s) begin
            b_data_r  <= bus.in_data;
            b_last_r  <= bus.in_last;
            b_valid_r <= 1'b1;
        end else if (b_valid_r && bus.b_ready) begin
            b_valid_r <= 1'b0;
        end else begin
            b_valid_r <= b_valid_r;
        end
    end

    // Completed-packet counters, bumped when a last beat enters a slot; wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_r <= '0;
            b_cnt_r <= '0;
        end else if (accept_s && bus.in_last) begin
            if (tgt_b_s) begin
                b_cnt_r <= b_cnt_r + CNT_ONE;
            end else begin
                a_cnt_r <= a_cnt_r + CNT_ONE;
            end
        end else begin
            a_cnt_r <= a_cnt_r;
            b_cnt_r <= b_cnt_r;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.a_data   = a_data_r;
    assign bus.a_last   = a_last_r;
    assign bus.a_valid  = a_valid_r;
    assign bus.b_data   = b_data_r;
    assign bus.b_last   = b_last_r;
    assign bus.b_valid  = b_valid_r;
    assign a_pkt_cnt    = a_cnt_r;
    assign b_pkt_cnt    = b_cnt_r;
endmodule
